// File: rtl/ps2_host_transmitter_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM encodings,
// keyboard command bytes, counter widths and the frame builder.
package ps2_host_transmitter_pkg;

  // FSM encodings, kept as plain constants so older tools and the receiver
  // side can share them without enum casts.
  localparam int         STATE_W     = 3;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_INHIBIT  = 3'd1;
  localparam logic [2:0] ST_RTS      = 3'd2;
  localparam logic [2:0] ST_SHIFT    = 3'd3;
  localparam logic [2:0] ST_ACK_WAIT = 3'd4;
  localparam logic [2:0] ST_RELEASE  = 3'd5;

  // Keyboard command bytes.
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

  localparam int PHASE_W   = 13;
  localparam int TIMEOUT_W = 20;
  localparam int BITCNT_W  = 4;
  localparam int FRAME_W   = 10;

  // Fall number 10 (bitcnt 9 before the increment) presents the stop bit.
  localparam logic [BITCNT_W-1:0] LAST_FRAME_BIT = 4'd9;

  typedef logic [FRAME_W-1:0] frame_t;

  // Frame as shifted out LSB first: d0..d7, odd parity, stop.
  function automatic frame_t build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

  // States in which the device owns the clock and the timeout runs.
  function automatic logic device_clocked(input logic [STATE_W-1:0] state);
    return (state == ST_SHIFT) || (state == ST_ACK_WAIT) || (state == ST_RELEASE);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock/data pair plus clock falling-edge
// detect; shared by the host transmitter and the device-to-host receiver.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ck_in,
  input  logic dt_in,
  output logic ck,
  output logic dt,
  output logic ck_fall
);

  logic [1:0] ck_pipe;
  logic [1:0] dt_pipe;
  logic       ck_prev;

  // Idle bus reads high, so the pipeline resets to 1 to avoid a false fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      ck_pipe <= 2'b11;
      dt_pipe <= 2'b11;
      ck_prev <= 1'b1;
    end else begin
      ck_pipe <= {ck_pipe[0], ck_in};
      dt_pipe <= {dt_pipe[0], dt_in};
      ck_prev <= ck_pipe[1];
    end
  end

  assign ck      = ck_pipe[1];
  assign dt      = dt_pipe[1];
  assign ck_fall = ck_prev & ~ck_pipe[1];

endmodule

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues
// request-to-send, shifts one byte on device clock falls and checks the ACK.
module ps2_host_transmitter
  import ps2_host_transmitter_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit,
  inout  wire        ps2ck,
  inout  wire        ps2dt
);

  localparam logic [PHASE_W-1:0]   INHIBIT_LAST = PHASE_W'(INHIBIT_CYCLES - 1);
  localparam logic [PHASE_W-1:0]   RTS_LAST     = PHASE_W'(RTS_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [STATE_W-1:0]   state;
  logic [PHASE_W-1:0]   phase_cnt;
  logic [TIMEOUT_W-1:0] timeout_cnt;
  logic [BITCNT_W-1:0]  bitcnt;
  frame_t               sr;
  logic                 ck_low;
  logic                 dt_low;

  logic ck_s;
  logic dt_s;
  logic ck_fall;
  logic accept;
  logic link_phase;
  logic timeout_hit;

  ps2_line_sync u_sync (
    .clk     (CLOCK_50),
    .rst     (rst),
    .ck_in   (ps2ck),
    .dt_in   (ps2dt),
    .ck      (ck_s),
    .dt      (dt_s),
    .ck_fall (ck_fall)
  );

  // NOTE: open-drain lines are only ever pulled low or released; the
  // external pull-up supplies the high level.
  assign ps2ck = ck_low ? 1'b0 : 1'bz;
  assign ps2dt = dt_low ? 1'b0 : 1'bz;

  // Busy covers the done/error pulse cycle so a start in that cycle is dropped.
  assign tx_busy     = (state != ST_IDLE) || tx_done || tx_error;
  assign rx_inhibit  = tx_busy;
  assign accept      = (state == ST_IDLE) && tx_start && !tx_busy;
  assign link_phase  = device_clocked(state);
  assign timeout_hit = link_phase && (timeout_cnt == TIMEOUT_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state       <= ST_IDLE;
      phase_cnt   <= '0;
      timeout_cnt <= '0;
      bitcnt      <= '0;
      ck_low      <= 1'b0;
      dt_low      <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle; a later non-blocking
      // assignment in the same block overrides the default.
      tx_done  <= 1'b0;
      tx_error <= 1'b0;

      if (link_phase) begin
        timeout_cnt <= timeout_cnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_INHIBIT;
            phase_cnt <= '0;
            ck_low    <= 1'b1;
            dt_low    <= 1'b0;
          end
        end

        ST_INHIBIT: begin
          if (phase_cnt == INHIBIT_LAST) begin
            state     <= ST_RTS;
            phase_cnt <= '0;
            dt_low    <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        // Data stays low as the start bit when the clock is handed over.
        ST_RTS: begin
          if (phase_cnt == RTS_LAST) begin
            state       <= ST_SHIFT;
            phase_cnt   <= '0;
            ck_low      <= 1'b0;
            bitcnt      <= '0;
            timeout_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (ck_fall) begin
            dt_low <= ~sr[0];
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == LAST_FRAME_BIT) begin
              state <= ST_ACK_WAIT;
            end
          end
        end

        ST_ACK_WAIT: begin
          if (ck_fall) begin
            if (dt_s) begin
              tx_error <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              state <= ST_RELEASE;
            end
          end
        end

        ST_RELEASE: begin
          if (ck_s && dt_s) begin
            tx_done <= 1'b1;
            state   <= ST_IDLE;
          end
        end

        default: begin
          state  <= ST_IDLE;
          ck_low <= 1'b0;
          dt_low <= 1'b0;
        end
      endcase

      // A silent or stuck device must never hold the bus indefinitely.
      if (timeout_hit) begin
        state    <= ST_IDLE;
        ck_low   <= 1'b0;
        dt_low   <= 1'b0;
        tx_done  <= 1'b0;
        tx_error <= 1'b1;
      end
    end
  end

  // NOTE: the shift register is pure datapath; it is always loaded before
  // use, so it carries no reset.
  always_ff @(posedge CLOCK_50) begin
    if (accept) begin
      sr <= build_frame(tx_data);
    end else if ((state == ST_SHIFT) && ck_fall) begin
      sr <= {1'b0, sr[FRAME_W-1:1]};
    end
  end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Self-checking bench: drives commands into the transmitter and plays the
// keyboard side of the link with a scaled-down device clock.
module tb_ps2_host_transmitter;
  import ps2_host_transmitter_pkg::*;

  localparam int INH  = 300;
  localparam int RTS  = 20;
  localparam int TO   = 3000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       rx_inhibit;
  wire        ps2ck;
  wire        ps2dt;

  logic dev_ck_low = 1'b0;
  logic dev_dt_low = 1'b0;

  assign ps2ck = dev_ck_low ? 1'b0 : 1'bz;
  assign ps2dt = dev_dt_low ? 1'b0 : 1'bz;
  pullup (ps2ck);
  pullup (ps2dt);

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int done_cyc = 0;
  int err_cyc  = 0;
  int rel_cyc  = 0;

  ps2_host_transmitter #(
    .INHIBIT_CYCLES (INH),
    .RTS_CYCLES     (RTS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLOCK_50   (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .rx_inhibit (rx_inhibit),
    .ps2ck      (ps2ck),
    .ps2dt      (ps2dt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (tx_error === 1'b1) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference frame as the device should see it: start, d0..d7, odd parity, stop.
  function automatic logic [10:0] expected_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_tx(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Counts cycles of host-held clock (and data) until the host hands the clock over.
  task automatic host_handshake(output int ck_n, output int dt_n, output bit ok);
    ck_n = 0;
    dt_n = 0;
    ok   = 1'b0;
    for (int n = 0; n < INH + RTS + 100; n++) begin
      if (ps2ck === 1'b1) begin
        ok = 1'b1;
        break;
      end
      ck_n++;
      if (ps2dt === 1'b0) dt_n++;
      @(negedge clk);
    end
  endtask

  // Device clocks out nbits bits, sampling data at each rising edge.
  task automatic device_clock_out(input int nbits, output logic [10:0] got);
    got    = '1;
    got[0] = ps2dt;
    tick(HALF);
    for (int i = 1; i <= nbits; i++) begin
      dev_ck_low = 1'b1;
      tick(HALF);
      dev_ck_low = 1'b0;
      got[i] = ps2dt;
      tick(HALF);
    end
  endtask

  task automatic device_ack(input bit ack_bit);
    dev_dt_low = !ack_bit;
    tick(5);
    dev_ck_low = 1'b1;
    tick(HALF);
    dev_ck_low = 1'b0;
    tick(4);
    dev_dt_low = 1'b0;
    rel_cyc    = cyc;
  endtask

  task automatic wait_outcome(input int done0, input int err0, input int bound, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(posedge clk);
      if (done_cnt != done0 || err_cnt != err0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++;
    if (tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_error !== 1'b0 || rx_inhibit !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b error=%b inhibit=%b, want all 0",
               tx_busy, tx_done, tx_error, rx_inhibit);
    end
    checks++;
    if (ps2ck !== 1'b1 || ps2dt !== 1'b1) begin
      errors++;
      $display("FAIL reset_lines: ck=%b dt=%b, want released (1,1)", ps2ck, ps2dt);
    end
    rst = 1'b0;
    tick(4);
    checks++;
    if (tx_busy !== 1'b0 || ps2ck !== 1'b1 || done_cnt != 0 || err_cnt != 0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b ck=%b done_cnt=%0d err_cnt=%0d, want 0,1,0,0",
               tx_busy, ps2ck, done_cnt, err_cnt);
    end
  endtask

  task automatic test_send(input string name, input logic [7:0] d, input bit ack_bit);
    logic [10:0] got;
    logic [10:0] want;
    int ck_n, dt_n, done0, err0;
    bit ok, seen;
    want  = expected_frame(d);
    done0 = done_cnt;
    err0  = err_cnt;
    start_tx(d);
    checks++;
    if (tx_busy !== 1'b1 || rx_inhibit !== 1'b1 || ps2ck !== 1'b0) begin
      errors++;
      $display("FAIL %s_latency: busy=%b inhibit=%b ck=%b one cycle after start, want 1,1,0",
               name, tx_busy, rx_inhibit, ps2ck);
    end
    host_handshake(ck_n, dt_n, ok);
    checks++;
    if (!ok || ck_n != INH + RTS) begin
      errors++;
      $display("FAIL %s_inhibit: ck low %0d cycles (released=%b), want %0d", name, ck_n, ok, INH + RTS);
    end
    checks++;
    if (dt_n != RTS || ps2dt !== 1'b0) begin
      errors++;
      $display("FAIL %s_rts: dt low %0d cycles before ck release, dt at release=%b, want %0d and 0",
               name, dt_n, ps2dt, RTS);
    end
    got = '0;
    if (ok) begin
      device_clock_out(10, got);
      device_ack(ack_bit);
    end
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s_frame: device saw %b, want %b (byte %h)", name, got, want, d);
    end
    wait_outcome(done0, err0, 400, seen);
    checks++;
    if (!seen || (done_cnt - done0) != int'(!ack_bit) || (err_cnt - err0) != int'(ack_bit)) begin
      errors++;
      $display("FAIL %s_outcome: done pulses %0d error pulses %0d, want %0d and %0d",
               name, done_cnt - done0, err_cnt - err0, int'(!ack_bit), int'(ack_bit));
    end
    if (!ack_bit) begin
      checks++;
      if (done_cyc - rel_cyc != 3) begin
        errors++;
        $display("FAIL %s_done_latency: tx_done %0d cycles after lines released, want 3",
                 name, done_cyc - rel_cyc);
      end
    end
    checks++;
    if (tx_busy !== 1'b0 || rx_inhibit !== 1'b0 || ps2ck !== 1'b1 || ps2dt !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle: busy=%b inhibit=%b ck=%b dt=%b after outcome, want 0,0,1,1",
               name, tx_busy, rx_inhibit, ps2ck, ps2dt);
    end
    tick(3);
    checks++;
    if ((done_cnt - done0) + (err_cnt - err0) != 1) begin
      errors++;
      $display("FAIL %s_single_pulse: %0d outcome pulses, want 1", name,
               (done_cnt - done0) + (err_cnt - err0));
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      test_send("random", d, 1'b0);
    end
  endtask

  task automatic test_ack_error();
    test_send("ack_one", 8'($urandom_range(0, 255)), 1'b1);
  endtask

  task automatic test_timeout();
    int ck_n, dt_n, c0, done0, err0;
    bit ok, seen;
    done0 = done_cnt;
    err0  = err_cnt;
    start_tx(8'($urandom_range(0, 255)));
    host_handshake(ck_n, dt_n, ok);
    c0 = cyc;
    wait_outcome(done0, err0, TO + 200, seen);
    checks++;
    if (!ok || !seen || err_cnt - err0 != 1 || err_cyc - c0 != TO) begin
      errors++;
      $display("FAIL timeout_time: error pulses %0d at %0d cycles after shift entry, want 1 at %0d",
               err_cnt - err0, err_cyc - c0, TO);
    end
    checks++;
    if (ps2ck !== 1'b1 || ps2dt !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_release: ck=%b dt=%b busy=%b, want 1,1,0", ps2ck, ps2dt, tx_busy);
    end
    tick(3);
    checks++;
    if (done_cnt != done0) begin
      errors++;
      $display("FAIL timeout_no_done: %0d done pulses, want 0", done_cnt - done0);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] got;
    int ck_n, dt_n, done0, err0;
    bit ok;
    done0 = done_cnt;
    err0  = err_cnt;
    start_tx(8'($urandom_range(0, 255)));
    host_handshake(ck_n, dt_n, ok);
    if (ok) device_clock_out(4, got);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (tx_busy !== 1'b0 || ps2ck !== 1'b1 || ps2dt !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: busy=%b ck=%b dt=%b cycle after reset, want 0,1,1 (handshake ok=%b)",
               tx_busy, ps2ck, ps2dt, ok);
    end
    tick(5);
    checks++;
    if (done_cnt != done0 || err_cnt != err0) begin
      errors++;
      $display("FAIL rst_mid_pulses: done %0d error %0d after reset, want 0 and 0",
               done_cnt - done0, err_cnt - err0);
    end
    test_send("after_rst", PS2_CMD_ENABLE, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [10:0] got;
    int ck_n, dt_n, done0, err0;
    bit ok;
    done0 = done_cnt;
    err0  = err_cnt;
    got   = '0;
    start_tx(PS2_CMD_RESET);
    start_tx(8'h55);
    host_handshake(ck_n, dt_n, ok);
    if (ok) begin
      start_tx(8'h55);
      device_clock_out(10, got);
      device_ack(1'b0);
    end
    checks++;
    if (got !== expected_frame(PS2_CMD_RESET)) begin
      errors++;
      $display("FAIL busy_ignore_frame: device saw %b, want %b", got, expected_frame(PS2_CMD_RESET));
    end
    for (int n = 0; n < 400 && tx_done !== 1'b1; n++) @(negedge clk);
    tx_data  = 8'h55;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    checks++;
    if (tx_busy !== 1'b0 || ps2ck !== 1'b1) begin
      errors++;
      $display("FAIL start_on_done: busy=%b ck=%b after start during done pulse, want 0,1",
               tx_busy, ps2ck);
    end
    tick(INH / 2);
    checks++;
    if (done_cnt - done0 != 1 || err_cnt != err0 || ps2ck !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_count: done %0d error %0d ck=%b, want 1, 0, 1",
               done_cnt - done0, err_cnt - err0, ps2ck);
    end
  endtask

  initial begin
    rst      = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    test_reset();
    test_send("leds", PS2_CMD_LEDS, 1'b0);
    test_send("zero", 8'h00, 1'b0);
    test_random();
    test_ack_error();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
